// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
package regfile_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } clr_state_t;

  // Widest data word the byte-merge helper handles; callers cast in and out.
  localparam int unsigned DMAX_W  = 1024;
  localparam int unsigned DMAX_BE = DMAX_W / 8;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  function automatic logic [DMAX_W-1:0] merge_be(input logic [DMAX_W-1:0]  old_d,
                                                 input logic [DMAX_W-1:0]  new_d,
                                                 input logic [DMAX_BE-1:0] be);
    logic [DMAX_W-1:0] r;
    for (int k = 0; k < int'(DMAX_BE); k++) begin
      r[8*k +: 8] = be[k] ? new_d[8*k +: 8] : old_d[8*k +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/regfile_clr_fsm.sv
// Sequential soft-clear engine: walks every entry once, then pulses done.
module regfile_clr_fsm
  import regfile_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_req,
  output logic          clr_busy,
  output logic          clr_done,
  output logic [AW-1:0] clr_addr
);

  clr_state_t state;

  // clr_busy doubles as the clear write strobe; clr_addr is the entry zeroed this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      clr_addr <= '0;
      clr_busy <= 1'b0;
      clr_done <= 1'b0;
    end else begin
      clr_done <= 1'b0;
      case (state)
        IDLE: begin
          if (clr_req) begin
            state    <= CLEAR;
            clr_addr <= '0;
            clr_busy <= 1'b1;
          end
        end
        CLEAR: begin
          if (clr_addr == AW'(DEPTH - 1)) begin
            state    <= DONE;
            clr_busy <= 1'b0;
            clr_done <= 1'b1;
          end else begin
            clr_addr <= clr_addr + AW'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with byte enables, bypass and soft clear.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int unsigned DATA_W  = 16,
  parameter  int unsigned DEPTH   = 16,
  parameter  int unsigned NUM_RD  = 2,
  parameter  int unsigned BYPASS  = 1,
  parameter  int unsigned ZERO_R0 = 0,
  localparam int unsigned AW      = clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [AW-1:0]            waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [DATA_W/8-1:0]      wbe,
  input  logic [NUM_RD*AW-1:0]     raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  input  logic                     clr_req,
  output logic                     clr_busy,
  output logic                     clr_done
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     clr_addr;
  logic              wr_ok_c;

  regfile_clr_fsm #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_clr_fsm (
    .clk      (clk),
    .rst      (rst),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .clr_done (clr_done),
    .clr_addr (clr_addr)
  );

  // A write commits only when idle, in range and not aimed at a hardwired-zero entry 0.
  assign wr_ok_c = we && !clr_busy && (32'(waddr) < DEPTH) &&
                   !((ZERO_R0 != 0) && (waddr == '0));

  always_ff @(posedge clk) begin
    if (rst) begin
      mem <= '{default: '0};
    end else if (clr_busy) begin
      mem[clr_addr] <= '0;
    end else if (wr_ok_c) begin
      mem[waddr] <= DATA_W'(merge_be(DMAX_W'(mem[waddr]), DMAX_W'(wdata), DMAX_BE'(wbe)));
    end
  end

  for (genvar p = 0; p < int'(NUM_RD); p++) begin : g_rd
    logic [AW-1:0]     ra;
    logic [DATA_W-1:0] stored;
    logic [DATA_W-1:0] rd;

    assign ra = raddr[p*AW +: AW];

    // Write-first bypass merges the pending byte lanes over the stored word.
    always_comb begin
      stored = '0;
      if ((32'(ra) < DEPTH) && !((ZERO_R0 != 0) && (ra == '0))) stored = mem[ra];
      rd = stored;
      if ((BYPASS != 0) && wr_ok_c && (ra == waddr)) begin
        rd = DATA_W'(merge_be(DMAX_W'(stored), DMAX_W'(wdata), DMAX_BE'(wbe)));
      end
    end

    assign rdata[p*DATA_W +: DATA_W] = rd;
  end

endmodule
